uart_transmitter: RTL

Serial transmit end of the CPU's memory-mapped UART. The memory controller hands it one byte per store to the UART transmit-data address, qualified by `data_in_valid`. It signals availability through `data_in_ready`, which the CPU polls via the UART control/status word. The block serialises each accepted byte as an 8N1 frame on `serial_out` at a fixed baud rate derived from the system clock.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_transmitter_if.sv | 10 +
 rtl/uart_baud_counter.sv | 36 +++
 rtl/uart_transmitter.sv | 104 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encodings, frame constants and the
// bit-period derivation used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Clock cycles per bit, truncated toward zero.
    function automatic int bit_period(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the memory controller (master) and the UART
// transmitter (slave).
interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (output data_in, output data_in_valid, input data_in_ready);
    modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..N-1 and pulses bit_done_o on the last cycle
// of every bit period. Shared by transmitter and receiver.
module uart_baud_counter #(
    parameter int N = 1085
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_done_o
);
    localparam int              CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_done_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per handshake while idle and
// serialises it start bit first, data LSB first, then one stop bit.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | line high, ready for a byte
// ST_START | driving the start bit (0) for one bit period
// ST_DATA  | driving shift_q[0], bit_idx_q selects data bit 0..7
// ST_STOP  | driving the stop bit (1) for one bit period
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_transmitter_if.slave    bus,
    output logic                 serial_out
);
    localparam int N = bit_period(CLOCK_FREQ, BAUD_RATE);

    generate
        if (N < 2) begin : g_bad_period
            $error("uart_transmitter: bit period must be at least 2 clock cycles");
        end
    endgenerate

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        serial_q, serial_d;
    logic        bit_done;

    // Held cleared while idle so the first bit period starts at count 0.
    uart_baud_counter #(.N(N)) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == ST_IDLE),
        .enable_i   (1'b1),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_in_valid) begin
                    shift_d   = bus.data_in;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the next state so serial_out changes on the same edge.
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[0];
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
        end
    end

    assign bus.data_in_ready = (state_q == ST_IDLE);
    assign serial_out        = serial_q;

endmodule
